// File: rtl/lut_cfg_chain.sv
// lut_cfg_chain: configurable look-up table loaded over a valid/ready word
// stream.
//
// A load is NWORDS = MEM_SIZE/CONFIG_WIDTH + 1 words long:
//   - words 0 .. NWORDS-2 fill the truth table, lowest bits first;
//   - the last word is the mode word: bit 0 = frac, bit 1 = regm.
//
// Output modes:
//   - frac=0: one INPUTS-input LUT. out0 = mem[addr], out1 = 0.
//   - frac=1: two (INPUTS-1)-input LUTs that share the low address bits.
//             out0 reads the lower half of mem, out1 the upper half.
//   - regm=0: outputs are combinational from addr.
//   - regm=1: outputs come from a register that loads when ce=1.
//
// Outputs stay 0 until a load has completed (cfg_done=1).
//
// Ports:
//   clk       - clock; all state changes on its rising edge
//   rst       - synchronous active-high reset
//   cfg_en    - request configuration mode (dropping it mid-load aborts)
//   cfg_valid - cfg_data holds a word
//   cfg_ready - a word is accepted this cycle (only while loading)
//   cfg_data  - configuration word
//   cfg_done  - configuration complete, outputs live
//   addr      - LUT address
//   ce        - output register enable (registered mode only)
//   out0      - primary LUT output
//   out1      - secondary output (fractured mode only, else 0)
module lut_cfg_chain #(
    parameter int INPUTS       = 4,
    parameter int MEM_SIZE     = 2 ** INPUTS,
    parameter int CONFIG_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_en,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [CONFIG_WIDTH-1:0] cfg_data,
    output logic                    cfg_done,
    input  logic [INPUTS-1:0]       addr,
    input  logic                    ce,
    output logic                    out0,
    output logic                    out1
);

    localparam int NWORDS = MEM_SIZE / CONFIG_WIDTH + 1;
    localparam int CNT_W  = $clog2(NWORDS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NWORDS - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]          state;
    logic [CNT_W-1:0]    cnt;
    logic [MEM_SIZE-1:0] mem;
    logic                frac;
    logic                regm;
    logic [1:0]          out_q;
    logic                lut0;
    logic                lut1;
    logic                xfer;
    logic [INPUTS-1:0]   lo_addr;
    logic [INPUTS-1:0]   hi_addr;

    assign cfg_ready = (state == LOAD);
    assign cfg_done  = (state == DONE);
    assign xfer      = cfg_valid && cfg_ready;

    // In fractured mode the top address bit picks the half of the table,
    // so the two halves are read in parallel with that bit forced.
    assign lo_addr = {1'b0, addr[INPUTS-2:0]};
    assign hi_addr = {1'b1, addr[INPUTS-2:0]};

    always_comb begin
        lut0 = 1'b0;
        lut1 = 1'b0;
        if (frac) begin
            lut0 = mem[lo_addr];
            lut1 = mem[hi_addr];
        end else begin
            lut0 = mem[addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            mem   <= '0;
            frac  <= 1'b0;
            regm  <= 1'b0;
            out_q <= 2'b00;
        end else begin
            // The output register only runs while the table is valid.
            // Otherwise it is cleared, so stale data never leaks out after
            // a reload.
            if (state != DONE) begin
                out_q <= 2'b00;
            end else if (ce) begin
                out_q <= {lut1, lut0};
            end

            case (state)
                IDLE: begin
                    if (cfg_en) begin
                        state <= LOAD;
                        cnt   <= '0;
                    end
                end
                LOAD: begin
                    // An abort drops any beat offered in the same cycle.
                    // Table bits written so far are kept.
                    if (!cfg_en) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (xfer) begin
                        if (cnt == LAST) begin
                            frac  <= cfg_data[0];
                            regm  <= cfg_data[1];
                            state <= DONE;
                        end else begin
                            for (int k = 0; k < NWORDS - 1; k++) begin
                                if (cnt == CNT_W'(k)) begin
                                    mem[k*CONFIG_WIDTH +: CONFIG_WIDTH] <= cfg_data;
                                end
                            end
                        end
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (cfg_en) begin
                        state <= LOAD;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        out0 = 1'b0;
        out1 = 1'b0;
        if (state == DONE) begin
            if (regm) begin
                out0 = out_q[0];
                out1 = out_q[1];
            end else begin
                out0 = lut0;
                out1 = lut1;
            end
        end
    end

endmodule

// File: tb/tb_lut_cfg_chain.sv
// Bench for lut_cfg_chain (INPUTS=4, CONFIG_WIDTH=4, five words per load).
// A spec-level model (phase, words received, table bits, mode flags,
// registered output pair) is checked against the DUT on every negedge.
// Directed scenarios add hand-computed literal expectations on top.
module tb_lut_cfg_chain;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_en = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [3:0] cfg_data = 4'h0;
    logic       cfg_done;
    logic [3:0] addr = 4'h0;
    logic       ce = 1'b0;
    logic       out0;
    logic       out1;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;
    int xfers = 0;

    lut_cfg_chain #(.INPUTS(4), .MEM_SIZE(16), .CONFIG_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready), .cfg_data(cfg_data), .cfg_done(cfg_done),
        .addr(addr), .ce(ce), .out0(out0), .out1(out1)
    );

    always #5 clk = ~clk;

    // ---------------- model ----------------
    // phase: 0 idle, 1 loading, 2 configured
    int         phase = 0;
    int         got = 0;
    bit [15:0]  mem_m = '0;
    bit         frac_m = 1'b0;
    bit         regm_m = 1'b0;
    bit [1:0]   oreg_m = 2'b00;

    function automatic bit [1:0] lut_m(input bit [3:0] a);
        bit [3:0] lo;
        bit [3:0] hi;
        lo = {1'b0, a[2:0]};
        hi = {1'b1, a[2:0]};
        if (frac_m) return {mem_m[hi], mem_m[lo]};
        return {1'b0, mem_m[a]};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            phase = 0; got = 0; mem_m = '0;
            frac_m = 0; regm_m = 0; oreg_m = 2'b00;
        end else begin
            if (phase != 2) oreg_m = 2'b00;
            else if (ce) oreg_m = lut_m(addr);
            if (phase == 0) begin
                if (cfg_en) begin phase = 1; got = 0; end
            end else if (phase == 1) begin
                if (!cfg_en) begin
                    phase = 0; got = 0;
                end else if (cfg_valid) begin
                    if (got == 4) begin
                        frac_m = cfg_data[0]; regm_m = cfg_data[1]; phase = 2;
                    end else begin
                        for (int b = 0; b < 4; b++) mem_m[got*4 + b] = cfg_data[b];
                        got++;
                    end
                end
            end else begin
                if (cfg_en) begin phase = 1; got = 0; end
            end
        end
    end

    always @(posedge clk) if (cfg_valid && cfg_ready) xfers++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            bit [1:0] e;
            e = 2'b00;
            if (phase == 2) e = regm_m ? oreg_m : lut_m(addr);
            check("cyc_ready", cfg_ready, 32'(phase == 1));
            check("cyc_done",  cfg_done,  32'(phase == 2));
            check("cyc_out0",  out0, 32'(e[0]));
            check("cyc_out1",  out1, 32'(e[1]));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // w[0] is sent first. gap inserts an idle cycle between words.
    task automatic load(input logic [4:0][3:0] w, input bit gap);
        cfg_en = 1'b1; cfg_valid = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            cfg_valid = 1'b1; cfg_data = w[i];
            step();
            if (gap && i < 4) begin
                cfg_valid = 1'b0; cfg_data = 4'hA;
                step();
            end
        end
        cfg_valid = 1'b0; cfg_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        step();
        chk_en = 1'b1;
        step();
        check("rst_ready", cfg_ready, 0);
        check("rst_done", cfg_done, 0);
        check("rst_out0", out0, 0);
        rst = 1'b0;
        step();

        // Single 4-input LUT, only address 15 set.
        load({4'h0, 4'h8, 4'h0, 4'h0, 4'h0}, 1'b0);
        check("l1_done", cfg_done, 1);
        for (int a = 0; a < 16; a++) begin
            addr = 4'(a);
            step();
            check("l1_out0", out0, 32'(a == 15));
            check("l1_out1", out1, 0);
        end

        // Fractured: mem[0]=1, mem[15]=1.
        load({4'h1, 4'h8, 4'h0, 4'h0, 4'h1}, 1'b0);
        addr = 4'd0;  #1; check("fr_a0",  {out1, out0}, 2'b01);
        addr = 4'd8;  #1; check("fr_a8",  {out1, out0}, 2'b01);
        addr = 4'd7;  #1; check("fr_a7",  {out1, out0}, 2'b10);
        addr = 4'd15; #1; check("fr_a15", {out1, out0}, 2'b10);
        step();

        // Registered mode, all-ones table.
        load({4'h2, 4'hF, 4'hF, 4'hF, 4'hF}, 1'b0);
        addr = 4'd3; ce = 1'b0;
        step(); check("rg_hold0a", out0, 0);
        step(); check("rg_hold0b", out0, 0);
        ce = 1'b1;
        step(); ce = 1'b0;
        check("rg_load", out0, 1);
        step(); check("rg_held", out0, 1);
        check("rg_out1", out1, 0);

        // Valid toggled every other cycle: exactly five transfers.
        xfers = 0;
        load({4'h0, 4'hC, 4'h3, 4'h5, 4'hA}, 1'b1);
        check("gap_xfers", xfers, 5);
        check("gap_done", cfg_done, 1);

        // Abort after two words (with a dropped beat), then a full reload.
        cfg_en = 1'b1; step();
        cfg_valid = 1'b1; cfg_data = 4'h0; step();
        cfg_data = 4'h0; step();
        cfg_en = 1'b0; cfg_data = 4'h0; step();
        cfg_valid = 1'b0;
        check("ab_done", cfg_done, 0);
        check("ab_ready", cfg_ready, 0);
        step();
        load({4'h0, 4'hF, 4'hF, 4'hF, 4'hF}, 1'b0);
        for (int a = 0; a < 16; a++) begin
            addr = 4'(a);
            #1;
            check("ab_all1", out0, 1);
        end
        step();

        // Reset while configured in registered mode.
        load({4'h2, 4'hF, 4'hF, 4'hF, 4'hF}, 1'b0);
        ce = 1'b1; step(); ce = 1'b0;
        check("rr_pre", out0, 1);
        rst = 1'b1; step(); rst = 1'b0;
        check("rr_done", cfg_done, 0);
        check("rr_out", {out1, out0}, 2'b00);
        step();
        load({4'h0, 4'h0, 4'h0, 4'h0, 4'h0}, 1'b0);
        for (int a = 0; a < 16; a++) begin
            addr = 4'(a);
            step();
            check("rr_zero", out0, 0);
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lut_cfg_chain.md
LUT_CFG_CHAIN -- requirements
Module: lut_cfg_chain

Interface
REQ-001 The block SHALL have parameter INPUTS, default 4, meaning the LUT address width (INPUTS >= 2).
REQ-002 The block SHALL have parameter MEM_SIZE, default 2**INPUTS, meaning the number of truth-table bits.
REQ-003 The block SHALL have parameter CONFIG_WIDTH, default 4, meaning config word width; MEM_SIZE SHALL be a multiple of CONFIG_WIDTH, and CONFIG_WIDTH >= 2.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset.
REQ-005 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst  input  1  synchronous active-high reset.
REQ-007 The block SHALL have port cfg_en  input  1  configuration mode request.
REQ-008 The block SHALL have port cfg_valid  input  1  cfg_data word valid.
REQ-009 The block SHALL have port cfg_ready  output  1  block accepts a config word this cycle.
REQ-010 The block SHALL have port cfg_data  input  CONFIG_WIDTH  config word.
REQ-011 The block SHALL have port cfg_done  output  1  configuration complete; outputs live.
REQ-012 The block SHALL have port addr  input  INPUTS  LUT address.
REQ-013 The block SHALL have port ce  input  1  output register clock enable.
REQ-014 The block SHALL have port out0  output  1  primary LUT output.
REQ-015 The block SHALL have port out1  output  1  secondary output in fractured mode.

Function
REQ-016 The block SHALL take NWORDS = MEM_SIZE/CONFIG_WIDTH + 1 words per load; a transfer occurs when cfg_valid && cfg_ready.
REQ-017 Word k (k < NWORDS-1) SHALL write mem[k*CONFIG_WIDTH +: CONFIG_WIDTH]; the final word SHALL set frac = cfg_data[0] and regm = cfg_data[1], other bits ignored.
REQ-018 The FSM SHALL have states IDLE, LOAD, DONE; IDLE->LOAD and DONE->LOAD when cfg_en=1, with word counter cleared to 0.
REQ-019 In LOAD, cfg_ready SHALL be 1; each transfer SHALL increment the word counter; the transfer of word NWORDS-1 SHALL move the FSM to DONE on the same edge.
REQ-020 cfg_done SHALL be 1 only in DONE; cfg_ready SHALL be 0 in IDLE and DONE.
REQ-021 cfg_en=0 in LOAD SHALL abort to IDLE next edge, keeping already-written mem bits, with the word counter cleared; a beat presented in the abort cycle SHALL be dropped.
REQ-022 Re-entering LOAD from DONE SHALL drop cfg_done on the next edge and restart at word 0.
REQ-023 frac=0: out0 SHALL equal mem[addr] and out1 SHALL be 0.
REQ-024 frac=1: out0 SHALL equal mem[{1'b0, addr[INPUTS-2:0]}] and out1 SHALL equal mem[{1'b1, addr[INPUTS-2:0]}]; addr[INPUTS-1] SHALL be ignored.
REQ-025 regm=0: outputs SHALL be combinational from addr, zero latency.
REQ-026 regm=1: outputs SHALL come from a 2-bit register loaded with the REQ-023/024 values on edges where ce=1, and held when ce=0; one-cycle latency.
REQ-027 The output register SHALL be cleared to 0 on any edge where the FSM is not in DONE.
REQ-028 When not in DONE, out0 and out1 SHALL be 0 regardless of mode.

Reset
REQ-029 On rst=1, the block SHALL clear mem, frac, regm, word counter and output register to 0, enter IDLE, and drive cfg_ready=0, cfg_done=0, out0=0, out1=0 from the next edge.
REQ-030 rst SHALL take priority over cfg_en, cfg_valid and ce; reset during LOAD SHALL discard progress.

Verification (INPUTS=4, CONFIG_WIDTH=4, NWORDS=5)
REQ-031 Load words 0x0,0x0,0x0,0x8,0x0 -> cfg_done=1 after fifth transfer; out0=1 only at addr=15; out1=0 everywhere.
REQ-032 Load 0x1,0x0,0x0,0x8,0x1 (frac) -> addr=0 and 8 give out0=1,out1=0; addr=7 and 15 give out0=0,out1=1.
REQ-033 Load 0xF,0xF,0xF,0xF,0x2 (regm), addr=3, ce held 0 -> out0=0; ce=1 one cycle -> out0=1 on the following cycle, held after ce=0.
REQ-034 cfg_valid toggled every other cycle during load -> exactly 5 transfers counted; cfg_done=1 only after fifth.
REQ-035 Drop cfg_en after 2 words, then reload fully with 0xFFFF, mode 0 -> cfg_done=0 between; final out0=1 for all addr.
REQ-036 Assert rst in DONE with regm=1 -> next cycle cfg_done=0, out0=out1=0, mem reads 0 after a reload of zeros.
